// File: rtl/rtc_time_counter.sv
// rtc_time_counter
//
// Timekeeping core of the RTC. A prescaler divides the system clock down to
// a once-per-second tick; on each tick the seconds, minutes, hours, day,
// month and year counters advance as one calendar cascade, including leap
// years (every year whose two low bits are zero, so 2000 counts as leap).
// All fields are plain binary, one byte each, ready for a BCD converter.
// Software can set the whole time and date through a validated load port.
// A rejected load leaves everything untouched and raises a one-cycle error.
//
// Optional feature (macro ALARM_EN): adds a daily hh:mm alarm that pulses
// alongside the tick that lands on hh:mm:00.
//
// Parameters:
//   CLK_HZ        system clock cycles per second (minimum 2)
//   PRE_W         prescaler width, 2^PRE_W must exceed CLK_HZ-1
//
// Ports:
//   i_clk         system clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_set_valid   one-cycle load request
//   i_set_sec     load seconds      0-59
//   i_set_min     load minutes      0-59
//   i_set_hour    load hours        0-23
//   i_set_days    load day          1-days in month
//   i_set_months  load month        1-12
//   i_set_years   load year offset  0-99 (2000-2099)
//   o_sec         seconds
//   o_min         minutes
//   o_hour        hours, 24 h
//   o_days        day of month
//   o_months      month
//   o_years       year offset from 2000
//   o_sec_tick    one-cycle pulse, fields have just advanced
//   o_set_err     one-cycle pulse, a load was rejected
//   i_alarm_arm   (ALARM_EN) alarm enable
//   i_alarm_hour  (ALARM_EN) alarm hour
//   i_alarm_min   (ALARM_EN) alarm minute
//   o_alarm       (ALARM_EN) one-cycle pulse with the matching tick

module rtc_time_counter #(
  parameter int CLK_HZ = 100000000,
  parameter int PRE_W  = 27
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_set_valid,
  input  logic [7:0] i_set_sec,
  input  logic [7:0] i_set_min,
  input  logic [7:0] i_set_hour,
  input  logic [7:0] i_set_days,
  input  logic [7:0] i_set_months,
  input  logic [7:0] i_set_years,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
  output logic [7:0] o_days,
  output logic [7:0] o_months,
  output logic [7:0] o_years,
  output logic       o_sec_tick,
  output logic       o_set_err
`ifdef ALARM_EN
  ,
  input  logic       i_alarm_arm,
  input  logic [7:0] i_alarm_hour,
  input  logic [7:0] i_alarm_min,
  output logic       o_alarm
`endif
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  // Month length; only the two low year bits matter because every year of
  // 2000-2099 that is divisible by four is a leap year.
  function automatic logic [7:0] daysInMonth(input logic [7:0] month,
                                             input logic [1:0] yearLow);
    logic [7:0] len;
    case (month)
      8'd2:                      len = (yearLow == 2'b00) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:   len = 8'd30;
      default:                   len = 8'd31;
    endcase
    return len;
  endfunction

  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_sec;
  logic [7:0]       r_min;
  logic [7:0]       r_hour;
  logic [7:0]       r_days;
  logic [7:0]       r_months;
  logic [7:0]       r_years;
  logic             r_tick;
  logic             r_err;

  logic             w_term;
  logic [7:0]       w_dim_now;
  logic [7:0]       w_dim_set;
  logic             w_set_ok;
  logic             w_load;

  logic             w_sec_wrap;
  logic             w_min_wrap;
  logic             w_hour_wrap;
  logic             w_day_wrap;
  logic             w_month_wrap;

  logic [7:0]       w_sec_nxt;
  logic [7:0]       w_min_nxt;
  logic [7:0]       w_hour_nxt;
  logic [7:0]       w_days_nxt;
  logic [7:0]       w_months_nxt;
  logic [7:0]       w_years_nxt;

  assign w_term    = (r_pre == PRE_LAST);
  assign w_dim_now = daysInMonth(r_months, r_years[1:0]);
  assign w_dim_set = daysInMonth(i_set_months, i_set_years[1:0]);

  // The day check uses the month length of the requested month and year,
  // not of the current date; an out-of-range month is rejected separately,
  // so the function's default length never lets a bad date through.
  assign w_set_ok = (i_set_sec    <  8'd60) &&
                    (i_set_min    <  8'd60) &&
                    (i_set_hour   <  8'd24) &&
                    (i_set_months != 8'd0)  &&
                    (i_set_months <= 8'd12) &&
                    (i_set_years  <  8'd100) &&
                    (i_set_days   != 8'd0)  &&
                    (i_set_days   <= w_dim_set);

  assign w_load = i_set_valid && w_set_ok;

  // Each wrap flag already includes every lower carry, so one tick can
  // roll everything from 23:59:59 31/12/99 to 00:00:00 1/1/00 in one edge.
  assign w_sec_wrap   = (r_sec == 8'd59);
  assign w_min_wrap   = w_sec_wrap  && (r_min == 8'd59);
  assign w_hour_wrap  = w_min_wrap  && (r_hour == 8'd23);
  assign w_day_wrap   = w_hour_wrap && (r_days == w_dim_now);
  assign w_month_wrap = w_day_wrap  && (r_months == 8'd12);

  // Next field values for a tick edge; a field only moves when the field
  // below it wraps.
  always_comb begin
    w_sec_nxt    = r_sec;
    w_min_nxt    = r_min;
    w_hour_nxt   = r_hour;
    w_days_nxt   = r_days;
    w_months_nxt = r_months;
    w_years_nxt  = r_years;

    w_sec_nxt = w_sec_wrap ? 8'd0 : r_sec + 8'd1;

    if (w_sec_wrap) begin
      w_min_nxt = (r_min == 8'd59) ? 8'd0 : r_min + 8'd1;
    end

    if (w_min_wrap) begin
      w_hour_nxt = (r_hour == 8'd23) ? 8'd0 : r_hour + 8'd1;
    end

    if (w_hour_wrap) begin
      w_days_nxt = w_day_wrap ? 8'd1 : r_days + 8'd1;
    end

    if (w_day_wrap) begin
      w_months_nxt = w_month_wrap ? 8'd1 : r_months + 8'd1;
    end

    if (w_month_wrap) begin
      w_years_nxt = (r_years == 8'd99) ? 8'd0 : r_years + 8'd1;
    end
  end

  // Prescaler, time fields and status pulses. A valid load takes priority
  // over a tick due on the same edge and restarts the one-second period;
  // a rejected load lets normal counting carry on untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre    <= '0;
      r_sec    <= 8'd0;
      r_min    <= 8'd0;
      r_hour   <= 8'd0;
      r_days   <= 8'd1;
      r_months <= 8'd1;
      r_years  <= 8'd0;
      r_tick   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_err  <= 1'b0;
      if (w_load) begin
        r_pre    <= '0;
        r_sec    <= i_set_sec;
        r_min    <= i_set_min;
        r_hour   <= i_set_hour;
        r_days   <= i_set_days;
        r_months <= i_set_months;
        r_years  <= i_set_years;
      end else begin
        if (i_set_valid) begin
          r_err <= 1'b1;
        end
        if (w_term) begin
          r_pre    <= '0;
          r_sec    <= w_sec_nxt;
          r_min    <= w_min_nxt;
          r_hour   <= w_hour_nxt;
          r_days   <= w_days_nxt;
          r_months <= w_months_nxt;
          r_years  <= w_years_nxt;
          r_tick   <= 1'b1;
        end else begin
          r_pre <= r_pre + PRE_W'(1);
        end
      end
    end
  end

  assign o_sec      = r_sec;
  assign o_min      = r_min;
  assign o_hour     = r_hour;
  assign o_days     = r_days;
  assign o_months   = r_months;
  assign o_years    = r_years;
  assign o_sec_tick = r_tick;
  assign o_set_err  = r_err;

`ifdef ALARM_EN
  logic r_alarm;
  logic w_alarm_hit;

  // The match is taken on the advanced time, so the pulse lines up with
  // the tick that produces hh:mm:00; loads never go through this path.
  assign w_alarm_hit = i_alarm_arm &&
                       (w_sec_nxt  == 8'd0) &&
                       (w_min_nxt  == i_alarm_min) &&
                       (w_hour_nxt == i_alarm_hour);

  // Alarm pulse register, only armed on a genuine tick edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= w_term && !w_load && w_alarm_hit;
    end
  end

  assign o_alarm = r_alarm;
`endif

endmodule

// File: tb/tb_rtc_time_counter.sv
// tb_rtc_time_counter
//
// Self-checking bench for rtc_time_counter with CLK_HZ=4. A reference model
// keeps the time as seconds elapsed since 2000-01-01 00:00:00 and turns
// that count back into calendar fields with plain arithmetic; every cycle
// the DUT outputs are compared with it. Table-driven rollover and invalid
// load cases plus hand-written corner sequences check against constants.
// Define ALARM_EN to build and check the alarm variant.

module tb_rtc_time_counter;

  localparam int     CLK_HZ = 4;
  localparam int     PRE_W  = 3;
  localparam longint SPAN   = 64'd3155760000;

  logic       clk = 1'b0;
  logic       rst;
  logic       setValid;
  logic [7:0] setSec, setMin, setHour, setDays, setMonths, setYears;
  logic [7:0] sec, min, hour, days, months, years;
  logic       secTick, setErr;
`ifdef ALARM_EN
  logic       alarmArm;
  logic [7:0] alarmHour, alarmMin;
  logic       alarm;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  longint mT    = 0;
  int     mPre  = 0;
  bit     mTick = 1'b0;
  bit     mErr  = 1'b0;
  bit     mAlarm = 1'b0;

  typedef struct {
    int h, mi, s, d, mo, y;
    int eh, emi, es, ed, emo, ey;
  } rollVec_t;

  typedef struct {
    int h, mi, s, d, mo, y;
    string name;
  } badVec_t;

  rollVec_t rollTab[8];
  badVec_t  badTab[10];

  always #5 clk = ~clk;

  rtc_time_counter #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_set_valid (setValid),
    .i_set_sec   (setSec),
    .i_set_min   (setMin),
    .i_set_hour  (setHour),
    .i_set_days  (setDays),
    .i_set_months(setMonths),
    .i_set_years (setYears),
    .o_sec       (sec),
    .o_min       (min),
    .o_hour      (hour),
    .o_days      (days),
    .o_months    (months),
    .o_years     (years),
    .o_sec_tick  (secTick),
    .o_set_err   (setErr)
`ifdef ALARM_EN
    ,
    .i_alarm_arm (alarmArm),
    .i_alarm_hour(alarmHour),
    .i_alarm_min (alarmMin),
    .o_alarm     (alarm)
`endif
  );

  // Calendar arithmetic of the reference model.
  function automatic int dimOf(input int mo, input int yr);
    if (mo == 2) return ((2000 + yr) % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic int yearLen(input int yr);
    return ((2000 + yr) % 4 == 0) ? 366 : 365;
  endfunction

  function automatic longint toSecs(input int yr, input int mo, input int d,
                                    input int h, input int mi, input int s);
    longint dd = 0;
    for (int yy = 0; yy < yr; yy++) dd += yearLen(yy);
    for (int m = 1; m < mo; m++) dd += dimOf(m, yr);
    dd += d - 1;
    return ((dd * 24 + h) * 60 + mi) * 60 + s;
  endfunction

  task automatic fromSecs(input longint t, output int yr, output int mo,
                          output int d, output int h, output int mi, output int s);
    longint dd;
    s  = int'(t % 60);
    mi = int'((t / 60) % 60);
    h  = int'((t / 3600) % 24);
    dd = t / 86400;
    yr = 0;
    while (dd >= yearLen(yr)) begin
      dd -= yearLen(yr);
      yr++;
    end
    mo = 1;
    while (dd >= dimOf(mo, yr)) begin
      dd -= dimOf(mo, yr);
      mo++;
    end
    d = int'(dd) + 1;
  endtask

  function automatic bit fieldsValid(input int h, input int mi, input int s,
                                     input int d, input int mo, input int y);
    if (s > 59 || mi > 59 || h > 23) return 1'b0;
    if (mo < 1 || mo > 12 || y > 99) return 1'b0;
    return (d >= 1 && d <= dimOf(mo, y));
  endfunction

  // Advance the model by one rising edge using the inputs present there.
  task automatic modelEdge();
    int yy, mo, dd, hh, mi, ss;
    if (rst) begin
      mT = 0; mPre = 0; mTick = 1'b0; mErr = 1'b0; mAlarm = 1'b0;
    end else begin
      mTick = 1'b0; mErr = 1'b0; mAlarm = 1'b0;
      if (setValid && fieldsValid(int'(setHour), int'(setMin), int'(setSec),
                                  int'(setDays), int'(setMonths), int'(setYears))) begin
        mT   = toSecs(int'(setYears), int'(setMonths), int'(setDays),
                      int'(setHour), int'(setMin), int'(setSec));
        mPre = 0;
      end else begin
        if (setValid) mErr = 1'b1;
        if (mPre == CLK_HZ - 1) begin
          mPre  = 0;
          mT    = (mT + 1) % SPAN;
          mTick = 1'b1;
`ifdef ALARM_EN
          fromSecs(mT, yy, mo, dd, hh, mi, ss);
          mAlarm = alarmArm && ss == 0 && mi == int'(alarmMin) && hh == int'(alarmHour);
`endif
        end else begin
          mPre++;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    int ey, emo, ed, eh, emi, es;
    bit bad;
    fromSecs(mT, ey, emo, ed, eh, emi, es);
    nCompared++;
    bad = ({hour, min, sec, days, months, years} !==
           {8'(eh), 8'(emi), 8'(es), 8'(ed), 8'(emo), 8'(ey)}) ||
          (secTick !== mTick) || (setErr !== mErr);
`ifdef ALARM_EN
    bad = bad || (alarm !== mAlarm);
`endif
    if (bad) begin
      nMismatched++;
      $display("[TB] FAIL %s @%0t: got %0d:%0d:%0d %0d/%0d/%0d tick=%b err=%b, expected %0d:%0d:%0d %0d/%0d/%0d tick=%b err=%b alarm=%b",
               tag, $time, hour, min, sec, days, months, years, secTick, setErr,
               eh, emi, es, ed, emo, ey, mTick, mErr, mAlarm);
    end
  endtask

  task automatic expectVal(input string tag, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s @%0t: got %0d expected %0d", tag, $time, actual, expected);
    end
  endtask

  task automatic expectFields(input string tag, input int h, input int mi, input int s,
                              input int d, input int mo, input int y);
    nCompared++;
    if ({hour, min, sec, days, months, years} !==
        {8'(h), 8'(mi), 8'(s), 8'(d), 8'(mo), 8'(y)}) begin
      nMismatched++;
      $display("[TB] FAIL %s @%0t: got %0d:%0d:%0d %0d/%0d/%0d expected %0d:%0d:%0d %0d/%0d/%0d",
               tag, $time, hour, min, sec, days, months, years, h, mi, s, d, mo, y);
    end
  endtask

  // One clock edge: update the model, then compare just after the edge.
  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("cycle");
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int h, input int mi,
                               input int s, input int d, input int mo, input int y);
    rst       = r;
    setValid  = v;
    setHour   = 8'(h);
    setMin    = 8'(mi);
    setSec    = 8'(s);
    setDays   = 8'(d);
    setMonths = 8'(mo);
    setYears  = 8'(y);
  endtask

  task automatic loadTime(input int h, input int mi, input int s,
                          input int d, input int mo, input int y);
    applyStimulus(1'b0, 1'b1, h, mi, s, d, mo, y);
    step();
    setValid = 1'b0;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rollTab[0] = '{23, 59, 59, 31, 12, 99,  0, 0, 0,  1, 1,  0};
    rollTab[1] = '{23, 59, 59, 28,  2, 24,  0, 0, 0, 29, 2, 24};
    rollTab[2] = '{23, 59, 59, 28,  2, 23,  0, 0, 0,  1, 3, 23};
    rollTab[3] = '{23, 59, 59, 30,  4, 10,  0, 0, 0,  1, 5, 10};
    rollTab[4] = '{23, 59, 59, 29,  2,  0,  0, 0, 0,  1, 3,  0};
    rollTab[5] = '{10, 59, 59, 15,  6,  5, 11, 0, 0, 15, 6,  5};
    rollTab[6] = '{12, 34, 56, 31,  1, 50, 12, 34, 57, 31, 1, 50};
    rollTab[7] = '{23, 59, 59, 31,  1,  7,  0, 0, 0,  1, 2,  7};

    badTab[0] = '{ 1,  2,  3, 30,  2, 24, "feb30 leap"};
    badTab[1] = '{24,  2,  3, 15,  3, 20, "hour24"};
    badTab[2] = '{ 1,  2,  3, 15,  0, 20, "month0"};
    badTab[3] = '{ 1,  2, 60, 15,  3, 20, "sec60"};
    badTab[4] = '{ 1, 60,  3, 15,  3, 20, "min60"};
    badTab[5] = '{ 1,  2,  3,  0,  3, 20, "day0"};
    badTab[6] = '{ 1,  2,  3, 15,  3,100, "year100"};
    badTab[7] = '{ 1,  2,  3, 29,  2, 23, "feb29 common"};
    badTab[8] = '{ 1,  2,  3, 31,  4, 10, "apr31"};
    badTab[9] = '{ 1,  2,  3, 15, 13, 20, "month13"};

`ifdef ALARM_EN
    alarmArm  = 1'b0;
    alarmHour = 8'd0;
    alarmMin  = 8'd0;
`endif
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

    // Reset values, then free-running ticks every four cycles.
    step();
    step();
    expectFields("reset fields", 0, 0, 0, 1, 1, 0);
    expectVal("reset tick", int'(secTick), 0);
    expectVal("reset err", int'(setErr), 0);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      expectVal("tick period", int'(secTick), (i % 4 == 0) ? 1 : 0);
    end
    expectVal("sec after 20 cycles", int'(sec), 5);

    // Rollover table: load, then the tick four cycles later.
    foreach (rollTab[k]) begin
      loadTime(rollTab[k].h, rollTab[k].mi, rollTab[k].s,
               rollTab[k].d, rollTab[k].mo, rollTab[k].y);
      expectFields("loaded", rollTab[k].h, rollTab[k].mi, rollTab[k].s,
                   rollTab[k].d, rollTab[k].mo, rollTab[k].y);
      expectVal("tick on load", int'(secTick), 0);
      for (int i = 1; i <= 3; i++) begin
        step();
        expectVal("no early tick", int'(secTick), 0);
      end
      step();
      expectVal("rollover tick", int'(secTick), 1);
      expectFields("rollover", rollTab[k].eh, rollTab[k].emi, rollTab[k].es,
                   rollTab[k].ed, rollTab[k].emo, rollTab[k].ey);
    end

    // Invalid load table: error pulse, fields unchanged.
    foreach (badTab[k]) begin
      loadTime(1, 2, 3, 15, 3, 20);
      applyStimulus(1'b0, 1'b1, badTab[k].h, badTab[k].mi, badTab[k].s,
                    badTab[k].d, badTab[k].mo, badTab[k].y);
      step();
      setValid = 1'b0;
      expectVal({"err ", badTab[k].name}, int'(setErr), 1);
      expectFields({"kept ", badTab[k].name}, 1, 2, 3, 15, 3, 20);
      step();
      expectVal({"err cleared ", badTab[k].name}, int'(setErr), 0);
    end

    // Invalid load on the terminal edge: the tick still happens.
    loadTime(1, 2, 3, 15, 3, 20);
    step(); step(); step();
    applyStimulus(1'b0, 1'b1, 1, 2, 3, 30, 2, 24);
    step();
    setValid = 1'b0;
    expectVal("bad load tick", int'(secTick), 1);
    expectVal("bad load err", int'(setErr), 1);
    expectFields("bad load advanced", 1, 2, 4, 15, 3, 20);

    // Valid load on the terminal edge wins over the tick.
    doReset();
    step(); step(); step();
    applyStimulus(1'b0, 1'b1, 10, 20, 30, 1, 1, 0);
    step();
    setValid = 1'b0;
    expectFields("load at terminal", 10, 20, 30, 1, 1, 0);
    expectVal("tick discarded", int'(secTick), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      expectVal("post-load tick", int'(secTick), (i == 4) ? 1 : 0);
    end
    expectVal("sec after load tick", int'(sec), 31);

    // Reset in the middle of a second.
    loadTime(12, 34, 56, 10, 10, 10);
    step(); step();
    expectFields("before mid reset", 12, 34, 56, 10, 10, 10);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    step();
    expectFields("mid reset", 0, 0, 0, 1, 1, 0);
    expectVal("mid reset tick", int'(secTick), 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      expectVal("first tick after reset", int'(secTick), (i == 4) ? 1 : 0);
    end

`ifdef ALARM_EN
    // Alarm at 00:01 fires once, on the tick reaching 00:01:00.
    alarmArm  = 1'b1;
    alarmHour = 8'd0;
    alarmMin  = 8'd1;
    loadTime(0, 0, 55, 1, 1, 0);
    for (int i = 1; i <= 24; i++) begin
      step();
      expectVal("alarm pulse", int'(alarm), (i == 20) ? 1 : 0);
    end
    loadTime(0, 1, 0, 1, 1, 0);
    expectVal("alarm on load", int'(alarm), 0);
    alarmMin = 8'd0;
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int h, mi, s, d, mo, y;
      if ($urandom_range(0, 1) == 1) begin
        h  = 23;
        mi = 59;
        s  = $urandom_range(57, 59);
        d  = $urandom_range(27, 31);
        mo = $urandom_range(1, 12);
        y  = $urandom_range(0, 99);
      end else begin
        h  = $urandom_range(0, 25);
        mi = $urandom_range(0, 63);
        s  = $urandom_range(0, 63);
        d  = $urandom_range(0, 32);
        mo = $urandom_range(0, 13);
        y  = $urandom_range(0, 101);
      end
`ifdef ALARM_EN
      alarmArm = 1'($urandom_range(0, 1));
`endif
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0,
                    h, mi, s, d, mo, y);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/rtc_time_counter.md
Name: rtc_time_counter

Overview:
Timekeeping core of the RTC. It divides the system clock down to a 1 Hz tick and advances binary seconds, minutes, hours, day, month and year counters, with full calendar handling including leap years. Its outputs feed binary_to_bcd directly, one 8-bit binary field per BCD converter input. A validated load port lets software set the time and date.

Parameters:
CLK_HZ, 100000000, system clock cycles per second; prescaler terminal count is CLK_HZ-1; minimum 2; benches use 4.
PRE_W, 27, prescaler width; must satisfy 2^PRE_W > CLK_HZ-1.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
set_valid  in  1  one-cycle load request
set_sec  in  8  load value, 0-59
set_min  in  8  load value, 0-59
set_hour  in  8  load value, 0-23
set_days  in  8  load value, 1-days_in_month
set_months  in  8  load value, 1-12
set_years  in  8  load value, 0-99 (2000-2099)
sec  out  8  binary seconds
min  out  8  binary minutes
hour  out  8  binary hours, 24 h
days  out  8  binary day of month
months  out  8  binary month
years  out  8  binary year offset from 2000
sec_tick  out  1  one-cycle pulse; time fields just advanced
set_err  out  1  one-cycle pulse; load rejected

Behaviour:
- Reset (rst=1 at an edge): prescaler=0, sec=min=hour=0, days=1, months=1, years=0, sec_tick=0, set_err=0. rst overrides set_valid and the tick.
- Prescaler counts 0..CLK_HZ-1.
  - On the edge where count==CLK_HZ-1: count goes to 0, time advances by one second, and sec_tick is registered high for exactly one cycle, coincident with the new field values.
  - Period is exactly CLK_HZ cycles.
- Advance cascade, all fields update on the same edge:
  - sec 59->0 carries to min.
  - min 59->0 carries to hour.
  - hour 23->0 carries to days.
  - days == days_in_month -> 1, carries to months.
  - months 12->1 carries to years.
  - years 99->0, wraps silently.
- days_in_month:
  - Jan, Mar, May, Jul, Aug, Oct, Dec = 31.
  - Apr, Jun, Sep, Nov = 30.
  - Feb = 29 if years[1:0]==0, else 28. Year 0 (2000) is a leap year.
- Load, on an edge with set_valid=1:
  - Valid when set_sec<60, set_min<60, set_hour<24, 1<=set_months<=12, set_years<100, and 1<=set_days<=days_in_month(set_months, set_years).
  - Valid load: all six fields take the set values on that edge, prescaler clears to 0, sec_tick=0 that cycle. The next tick follows CLK_HZ cycles later.
  - Invalid load: fields and prescaler unchanged (normal ticking continues, including a tick due that edge); set_err pulses for one cycle on the next cycle.
- set_valid and prescaler terminal count on the same edge: a valid load wins and the tick is discarded.
- Outputs are registered; no combinational path from inputs to outputs.
- Fields never hold out-of-range values, provided reset has been applied.
- The combinational day/month/leap logic must fit one clock at target frequency; no multi-cycle paths.

Optional Feature:
ALARM_EN.
- Defined: adds inputs alarm_arm (1), alarm_hour (8), alarm_min (8) and output alarm (1).
  - alarm pulses for one cycle, coincident with sec_tick, when the advanced time has sec==0, min==alarm_min, hour==alarm_hour, and alarm_arm=1.
  - A valid load landing on a matching hh:mm:00 does not fire the alarm.
  - alarm resets to 0.
- Not defined: these ports and the alarm logic do not exist; all other behaviour is identical.

Test Plan:
- Reset with CLK_HZ=4: after rst, fields read 0:0:0, day 1, month 1, year 0. sec_tick pulses every 4 cycles, and sec reaches 5 after 20 cycles.
- Load 23:59:59 31/12/99, wait one tick: fields read 0:0:0, day 1, month 1, year 0, with sec_tick high on that same cycle.
- Leap year: load 23:59:59 28/2/24 -> tick -> 29/2/24; load 23:59:59 28/2/23 -> tick -> 1/3/23; load 23:59:59 30/4/10 -> tick -> 1/5/10.
- Invalid load 30/2/24 (also hour=24, month=0): set_err pulses once; fields are unchanged and ticking continues.
- set_valid asserted on the terminal-count cycle with a load of 10:20:30: fields read 10:20:30 and no sec_tick occurs. The next tick comes exactly 4 cycles later, giving sec=31.
- rst asserted mid-count with the prescaler at 2 and time 12:34:56: the next cycle shows reset values, and the first tick arrives 4 cycles after rst deasserts. With ALARM_EN, alarm set to 0:1 and armed: alarm pulses once when time reaches 0:1:0.
